// File: rtl/dac_top_level.sv
// Segmented current-steering DAC model: 17 unary MSB segments plus 7 binary LSBs, real-valued outputs.
// Data is registered once on clkin, outputs follow the registers combinationally, and there is no flow control.
module dac_top_level #(
   parameter int  N_BIN     = 7,
   parameter int  N_THERM   = 17,
   parameter real RCAL      = 1000.0,
   parameter real VDD18_MIN = 1.62,
   parameter real VDD08_MIN = 0.72
) (
   input  logic               clkin,
   input  logic               pdb,
   input  logic               clkinb,
   input  logic [0:N_BIN-1]   datainbin,
   input  logic [0:N_BIN-1]   datainbinb,
   input  logic [0:N_THERM-1] dataintherm,
   input  logic [0:N_THERM-1] datainthermb,
   input  logic [0:9]         atb_ena,
   input  real                dataical,
   input  real                vddana_0p8,
   input  real                vddana_1p8,
   input  real                vssana,
   output real                Vout,
   output real                Voutb,
   output real                Ical,
   output real                atb [0:9]
);

   localparam int CNT_W    = $clog2(N_THERM + 1);
   localparam int CODE_W   = CNT_W + N_BIN;
   localparam int CODE_MAX = N_THERM * (2 ** N_BIN) + (2 ** N_BIN) - 1;

   logic               w_unused_clkinb;
   logic [N_BIN-1:0]   w_bin_t, w_bin_c, w_bin_vld, w_bin_nxt, r_bin;
   logic [N_THERM-1:0] w_th_t, w_th_c, w_th_vld, w_th_nxt, r_therm;
   logic [CNT_W-1:0]   w_therm_cnt;
   logic [CODE_W-1:0]  w_code;
   logic               w_supply_ok;
   real                w_vfs, w_vout, w_voutb, w_ical;
   real                w_src [0:9];

   assign w_unused_clkinb = clkinb;

   // Index 0 of the ports is the MSB, so a straight vector copy keeps the numeric value.
   assign w_bin_t = datainbin;
   assign w_bin_c = datainbinb;
   assign w_th_t  = dataintherm;
   assign w_th_c  = datainthermb;

   // A bit whose true/complement pair agrees is invalid and keeps its registered value.
   assign w_bin_vld = w_bin_t ^ w_bin_c;
   assign w_th_vld  = w_th_t ^ w_th_c;
   assign w_bin_nxt = (w_bin_vld & w_bin_t) | (~w_bin_vld & r_bin);
   assign w_th_nxt  = (w_th_vld & w_th_t) | (~w_th_vld & r_therm);

   always_ff @(posedge clkin or negedge pdb) begin
      if (!pdb) begin
         r_bin   <= '0;
         r_therm <= '0;
      end else begin
         r_bin   <= w_bin_nxt;
         r_therm <= w_th_nxt;
      end
   end

   // Popcount tolerates thermometer bubbles without any ordering check.
   always_comb begin
      w_therm_cnt = '0;
      for (int i = 0; i < N_THERM; i++) begin
         w_therm_cnt = w_therm_cnt + {{(CNT_W-1){1'b0}}, r_therm[i]};
      end
   end

   assign w_code      = {w_therm_cnt, {N_BIN{1'b0}}} + {{CNT_W{1'b0}}, r_bin};
   assign w_supply_ok = (vddana_1p8 >= VDD18_MIN) && (vddana_0p8 >= VDD08_MIN);

   always_comb begin
      w_vfs   = vddana_0p8 - vssana;
      w_vout  = vssana;
      w_voutb = vssana;
      w_ical  = 0.0;
      if (pdb && w_supply_ok) begin
         w_vout  = vssana + w_vfs * real'(w_code) / real'(CODE_MAX);
         w_voutb = vssana + w_vfs * real'(CODE_MAX - int'(w_code)) / real'(CODE_MAX);
         w_ical  = dataical / RCAL;
      end
   end

   always_comb begin
      w_src[0] = w_vout;
      w_src[1] = w_voutb;
      w_src[2] = dataical;
      w_src[3] = vddana_0p8;
      w_src[4] = vddana_1p8;
      w_src[5] = vssana;
      w_src[6] = (w_vout + w_voutb) / 2.0;
      w_src[7] = real'(w_therm_cnt);
      w_src[8] = real'(r_bin);
      w_src[9] = real'(w_code) / real'(CODE_MAX);
      Vout     = w_vout;
      Voutb    = w_voutb;
      Ical     = w_ical;
      for (int i = 0; i < 10; i++) begin
         atb[i] = 0.0;
         if (pdb && atb_ena[i]) begin
            atb[i] = w_src[i];
         end
      end
   end

endmodule

// File: tb/tb_dac_top_level.sv
// Directed bench for dac_top_level: reset, code weighting, pair decode, latency, supplies and test bus.
module tb_dac_top_level;

   logic        clkin;
   logic        clkinb;
   logic        pdb;
   logic [0:6]  datainbin;
   logic [0:6]  datainbinb;
   logic [0:16] dataintherm;
   logic [0:16] datainthermb;
   logic [0:9]  atb_ena;
   real         dataical;
   real         vddana_0p8;
   real         vddana_1p8;
   real         vssana;
   real         Vout;
   real         Voutb;
   real         Ical;
   real         atb [0:9];

   int n_cmp = 0;
   int n_err = 0;

   dac_top_level dut (
      .clkin        (clkin),
      .pdb          (pdb),
      .clkinb       (clkinb),
      .datainbin    (datainbin),
      .datainbinb   (datainbinb),
      .dataintherm  (dataintherm),
      .datainthermb (datainthermb),
      .atb_ena      (atb_ena),
      .dataical     (dataical),
      .vddana_0p8   (vddana_0p8),
      .vddana_1p8   (vddana_1p8),
      .vssana       (vssana),
      .Vout         (Vout),
      .Voutb        (Voutb),
      .Ical         (Ical),
      .atb          (atb)
   );

   initial clkin = 1'b0;
   always #5 clkin = ~clkin;
   assign clkinb = ~clkin;

   task automatic chk(input string tag, input real act, input real exp);
      real d;
      n_cmp++;
      d = act - exp;
      if (d < 0.0) d = -d;
      if (d > 1.0e-6) begin
         n_err++;
         $display("FAIL %s: got %g expected %g", tag, act, exp);
      end
   endtask

   task automatic drive(input logic [0:16] th, input logic [0:6] bn);
      dataintherm  = th;
      datainthermb = ~th;
      datainbin    = bn;
      datainbinb   = ~bn;
   endtask

   task automatic step;
      @(posedge clkin);
      #1;
   endtask

   initial begin
      pdb        = 1'b0;
      atb_ena    = 10'b11_1111_1111;
      dataical   = 0.5;
      vddana_0p8 = 0.8;
      vddana_1p8 = 1.8;
      vssana     = 0.0;
      drive(17'h1FFFF, 7'h7F);

      // held in reset with all-ones data and a running clock
      repeat (3) @(posedge clkin);
      #1;
      chk("rst_vout", Vout, 0.0);
      chk("rst_voutb", Voutb, 0.0);
      chk("rst_ical", Ical, 0.0);
      chk("rst_atb2", atb[2], 0.0);
      chk("rst_atb4", atb[4], 0.0);
      chk("rst_atb7", atb[7], 0.0);
      #2 pdb = 1'b1;
      #1;
      chk("rel_hold_vout", Vout, 0.0);
      step;
      chk("full_vout", Vout, 0.8);
      chk("full_voutb", Voutb, 0.0);
      chk("full_atb7", atb[7], 17.0);
      chk("full_atb8", atb[8], 127.0);
      chk("full_atb9", atb[9], 1.0);

      // midscale: 9 segments, code 1152
      drive(17'b11111111100000000, 7'b0000000);
      step;
      chk("mid_vout", Vout, 0.8 * 1152.0 / 2303.0);
      chk("mid_voutb", Voutb, 0.8 * 1151.0 / 2303.0);
      chk("mid_atb7", atb[7], 9.0);
      chk("mid_atb6", atb[6], 0.4);

      // LSB and binary MSB weighting
      drive(17'h0, 7'b0000001);
      step;
      chk("lsb_vout", Vout, 0.8 / 2303.0);
      chk("lsb_atb8", atb[8], 1.0);
      drive(17'h0, 7'b1000000);
      step;
      chk("b64_vout", Vout, 0.8 * 64.0 / 2303.0);
      chk("b64_atb8", atb[8], 64.0);

      // invalid pair on the LSB holds its previous value of 1
      drive(17'h0, 7'b0000001);
      step;
      datainbin  = 7'b0000001;
      datainbinb = 7'b1111111;
      step;
      chk("inv_hi_atb8", atb[8], 1.0);
      chk("inv_hi_vout", Vout, 0.8 / 2303.0);
      datainbin  = 7'b0000000;
      datainbinb = 7'b1111110;
      step;
      chk("inv_lo_atb8", atb[8], 1.0);

      // invalid pair on a segment holds its previous value of 0
      drive(17'h0, 7'b0000000);
      dataintherm  = 17'b00100000000000000;
      datainthermb = 17'b11111111111111111;
      step;
      chk("inv_th_atb7", atb[7], 0.0);

      // bubbled thermometer pattern 101 counts as 2 segments
      drive(17'b10100000000000000, 7'b0000000);
      step;
      chk("bub_atb7", atb[7], 2.0);
      chk("bub_vout", Vout, 0.8 * 256.0 / 2303.0);

      // data change between edges is not visible until the next rise
      drive(17'h1FFFF, 7'h7F);
      #1;
      chk("lat_hold", Vout, 0.8 * 256.0 / 2303.0);
      step;
      chk("lat_load", Vout, 0.8);

      // asynchronous power-down mid-cycle, then wait for the first edge
      #2 pdb = 1'b0;
      #1;
      chk("pd_vout", Vout, 0.0);
      chk("pd_voutb", Voutb, 0.0);
      chk("pd_atb7", atb[7], 0.0);
      #1 pdb = 1'b1;
      #1;
      chk("pd_rel_vout", Vout, 0.0);
      step;
      chk("pd_reload", Vout, 0.8);

      // calibration current and supply checks
      #1;
      chk("ical", Ical, 5.0e-4);
      chk("atb2", atb[2], 0.5);
      vddana_1p8 = 1.5;
      #1;
      chk("bo18_vout", Vout, 0.0);
      chk("bo18_voutb", Voutb, 0.0);
      chk("bo18_ical", Ical, 0.0);
      chk("bo18_atb4", atb[4], 1.5);
      vddana_1p8 = 1.62;
      #1;
      chk("edge18_vout", Vout, 0.8);
      vddana_0p8 = 0.7;
      #1;
      chk("bo08_voutb", Voutb, 0.0);
      chk("bo08_vout", Vout, 0.0);
      chk("bo08_atb3", atb[3], 0.7);
      vddana_0p8 = 0.8;
      vssana     = 0.1;
      #1;
      chk("vss_vout", Vout, 0.8);
      chk("vss_voutb", Voutb, 0.1);
      chk("vss_atb5", atb[5], 0.1);
      chk("vss_atb6", atb[6], 0.45);
      vssana = 0.0;

      // test bus gating
      atb_ena = 10'b00_0000_0000;
      #1;
      for (int i = 0; i < 10; i++) begin
         chk($sformatf("atb_off%0d", i), atb[i], 0.0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
